// File: rtl/axi_route_pkg.sv
// Shared types and helpers for the AXI write-data router.
// route_t holds one queued {master, slave} routing decision.
package axi_route_pkg;

    // Route fields are stored at a fixed width so the FIFO stays generic;
    // routers narrower than this zero-extend their indices.
    localparam int ROUTE_IDX_W = 4;

    // Default read-only map: slave 0 is the boot ROM.
    localparam logic [5:0] RO_SLV_MASK_DEF = 6'b000001;

    typedef struct packed {
        logic [ROUTE_IDX_W-1:0] mst;
        logic [ROUTE_IDX_W-1:0] slv;
    } route_t;

    // Width of an index able to address n items (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an occupancy counter that counts 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axi_route_fifo.sv
// In-order FIFO of route_t entries, DEPTH deep (power of 2, >= 2).
// A push while full and a pop while empty are ignored.
module axi_route_fifo
    import axi_route_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  route_t                    din,
    output route_t                    dout,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    route_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_wdata_router.sv
// AXI W-channel router: steers W beats from the head route's master to its
// slave, in AW order, with several bursts outstanding. Writes aimed at a
// read-only or non-existent slave are absorbed and flagged on wr_err.
// Optional feature macro: AXI_WROUTE_BYPASS_EN (route from an AW push in the
// same cycle when the route FIFO is empty).
module axi_wdata_router
    import axi_route_pkg::*;
#(
    parameter int               NUM_M       = 3,
    parameter int               NUM_S       = 6,
    parameter int               DATA_W      = 32,
    parameter int               STRB_W      = DATA_W / 8,
    parameter int               DEPTH       = 4,
    parameter logic [NUM_S-1:0] RO_SLV_MASK = NUM_S'(RO_SLV_MASK_DEF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        aw_push,
    input  logic [idx_w(NUM_M)-1:0]     aw_mst,
    input  logic [idx_w(NUM_S)-1:0]     aw_slv,
    output logic                        aw_ready,
    input  logic [NUM_M*DATA_W-1:0]     wdata_m,
    input  logic [NUM_M*STRB_W-1:0]     wstrb_m,
    input  logic [NUM_M-1:0]            wlast_m,
    input  logic [NUM_M-1:0]            wvalid_m,
    output logic [NUM_M-1:0]            wready_m,
    output logic [NUM_S*DATA_W-1:0]     wdata_s,
    output logic [NUM_S*STRB_W-1:0]     wstrb_s,
    output logic [NUM_S-1:0]            wlast_s,
    output logic [NUM_S-1:0]            wvalid_s,
    input  logic [NUM_S-1:0]            wready_s,
    output logic                        wr_err,
    output logic [cnt_w(DEPTH)-1:0]     outstanding
);

    route_t              aw_route;
    route_t              head;
    route_t              route;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                route_vld;
    logic                m_ok;
    logic                writable;
    logic                sel_vld;
    logic                sel_last;
    logic                sel_rdy;
    logic [DATA_W-1:0]   sel_data;
    logic [STRB_W-1:0]   sel_strb;
    logic                beat;
    logic                done;
    logic                sink;

    assign aw_route = '{mst: ROUTE_IDX_W'(aw_mst), slv: ROUTE_IDX_W'(aw_slv)};

    axi_route_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (aw_route),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    assign aw_ready = !fifo_full;
    assign fifo_pop = done && !fifo_empty;

`ifdef AXI_WROUTE_BYPASS_EN
    // With an empty FIFO the incoming AW routes directly; a burst that ends
    // in that same cycle never needs a FIFO entry.
    logic byp;
    assign byp       = fifo_empty && aw_push && !rst;
    assign route_vld = (!fifo_empty || aw_push) && !rst;
    assign route     = fifo_empty ? aw_route : head;
    assign fifo_push = aw_push && !(byp && done);
`else
    // Routing only ever comes from the registered head entry.
    assign route_vld = !fifo_empty && !rst;
    assign route     = head;
    assign fifo_push = aw_push;
`endif

    // Route mux, read-only sink and beat/last detection for the active route.
    // A master index outside NUM_M selects nothing, so no beat is accepted.
    always_comb begin
        wready_m = '0;
        wvalid_s = '0;
        wdata_s  = '0;
        wstrb_s  = '1;
        wlast_s  = '0;
        m_ok     = 1'b0;
        writable = 1'b0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_rdy  = 1'b0;
        sel_data = '0;
        sel_strb = '1;
        beat     = 1'b0;
        done     = 1'b0;
        sink     = 1'b0;

        for (int i = 0; i < NUM_M; i++) begin
            if (route_vld && int'(route.mst) == i) begin
                m_ok     = 1'b1;
                sel_vld  = wvalid_m[i];
                sel_last = wlast_m[i];
                sel_data = wdata_m[i*DATA_W +: DATA_W];
                sel_strb = wstrb_m[i*STRB_W +: STRB_W];
            end
        end

        for (int s = 0; s < NUM_S; s++) begin
            if (int'(route.slv) == s && !RO_SLV_MASK[s]) begin
                writable = 1'b1;
                sel_rdy  = wready_s[s];
            end
        end

        if (m_ok) begin
            if (writable) begin
                beat = sel_vld && sel_rdy;
                for (int s = 0; s < NUM_S; s++) begin
                    if (int'(route.slv) == s) begin
                        wvalid_s[s]                  = sel_vld;
                        wdata_s[s*DATA_W +: DATA_W]  = sel_data;
                        wstrb_s[s*STRB_W +: STRB_W]  = sel_strb;
                        wlast_s[s]                   = sel_last;
                    end
                end
            end else begin
                sink = 1'b1;
                beat = sel_vld;
            end
            for (int i = 0; i < NUM_M; i++) begin
                if (int'(route.mst) == i) wready_m[i] = beat;
            end
            done = beat && sel_last;
        end
    end

    // One-cycle error pulse after the last beat of an absorbed burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= sink && done;
    end

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router (default parameters: 3 masters,
// 6 slaves, 32-bit data, depth 4, slave 0 read-only).
module tb_axi_wdata_router;

    logic          clk;
    logic          rst;
    logic          aw_push;
    logic [1:0]    aw_mst;
    logic [2:0]    aw_slv;
    logic          aw_ready;
    logic [95:0]   wdata_m;
    logic [11:0]   wstrb_m;
    logic [2:0]    wlast_m;
    logic [2:0]    wvalid_m;
    logic [2:0]    wready_m;
    logic [191:0]  wdata_s;
    logic [23:0]   wstrb_s;
    logic [5:0]    wlast_s;
    logic [5:0]    wvalid_s;
    logic [5:0]    wready_s;
    logic          wr_err;
    logic [2:0]    outstanding;

    int n_checks = 0;
    int n_err    = 0;

    axi_wdata_router dut (
        .clk         (clk),
        .rst         (rst),
        .aw_push     (aw_push),
        .aw_mst      (aw_mst),
        .aw_slv      (aw_slv),
        .aw_ready    (aw_ready),
        .wdata_m     (wdata_m),
        .wstrb_m     (wstrb_m),
        .wlast_m     (wlast_m),
        .wvalid_m    (wvalid_m),
        .wready_m    (wready_m),
        .wdata_s     (wdata_s),
        .wstrb_s     (wstrb_s),
        .wlast_s     (wlast_s),
        .wvalid_s    (wvalid_s),
        .wready_s    (wready_s),
        .wr_err      (wr_err),
        .outstanding (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input int s);
        aw_push = 1'b1;
        aw_mst  = 2'(m);
        aw_slv  = 3'(s);
        tick();
        aw_push = 1'b0;
    endtask

    task automatic set_beat(input int m, input logic [31:0] d, input logic [3:0] st, input logic l);
        wdata_m[m*32 +: 32] = d;
        wstrb_m[m*4 +: 4]   = st;
        wlast_m[m]          = l;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wvalid_s"}, 64'(wvalid_s), 64'(0));
        check({tag, "_wready_m"}, 64'(wready_m), 64'(0));
        check({tag, "_wdata_s"}, 64'(wdata_s != '0), 64'(0));
        check({tag, "_wstrb_s"}, 64'(wstrb_s), 64'(24'hFFFFFF));
        check({tag, "_wlast_s"}, 64'(wlast_s), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        aw_push  = 1'b0;
        aw_mst   = '0;
        aw_slv   = '0;
        wdata_m  = '0;
        wstrb_m  = '1;
        wlast_m  = '0;
        wvalid_m = '0;
        wready_s = '0;
        tick();
        tick();

        // Reset state
        check("rst_aw_ready", 64'(aw_ready), 64'(1));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_wr_err", 64'(wr_err), 64'(0));
        check_idle("rst");
        rst = 1'b0;
        tick();

        // Test 1: M1 -> S2, 4-beat burst
        push(1, 2);
        check("t1_outstanding_after_push", 64'(outstanding), 64'(1));
        wready_s    = 6'b111111;
        wvalid_m[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(1, 32'hA000_0000 + 32'(k), 4'h5, (k == 3));
            #1;
            check("t1_wvalid_s", 64'(wvalid_s), 64'(6'b000100));
            check("t1_wready_m", 64'(wready_m), 64'(3'b010));
            check("t1_wdata_s2", 64'(wdata_s[2*32 +: 32]), 64'(32'hA000_0000 + 32'(k)));
            check("t1_wlast_s", 64'(wlast_s), (k == 3) ? 64'(6'b000100) : 64'(0));
            tick();
        end
        wvalid_m = '0;
        wlast_m  = '0;
        #1;
        check("t1_outstanding_end", 64'(outstanding), 64'(0));
        check("t1_wready_m_end", 64'(wready_m), 64'(0));

        // Test 2: three queued routes drained strictly in order
        push(0, 1);
        push(2, 5);
        push(1, 3);
        check("t2_outstanding", 64'(outstanding), 64'(3));
        set_beat(0, 32'h1000_0000, 4'h1, 1'b1);
        set_beat(1, 32'h1111_1111, 4'h3, 1'b1);
        set_beat(2, 32'h2222_2222, 4'h8, 1'b1);
        wvalid_m = 3'b111;
        #1;
        check("t2_c1_wvalid_s", 64'(wvalid_s), 64'(6'b000010));
        check("t2_c1_wready_m", 64'(wready_m), 64'(3'b001));
        check("t2_c1_wdata_s1", 64'(wdata_s[1*32 +: 32]), 64'(32'h1000_0000));
        check("t2_c1_wstrb_s", 64'(wstrb_s), 64'(24'hFFFF1F));
        tick();
        check("t2_c2_wvalid_s", 64'(wvalid_s), 64'(6'b100000));
        check("t2_c2_wready_m", 64'(wready_m), 64'(3'b100));
        check("t2_c2_wdata_s5", 64'(wdata_s[5*32 +: 32]), 64'(32'h2222_2222));
        check("t2_c2_wstrb_s", 64'(wstrb_s), 64'(24'h8FFFFF));
        tick();
        check("t2_c3_wvalid_s", 64'(wvalid_s), 64'(6'b001000));
        check("t2_c3_wready_m", 64'(wready_m), 64'(3'b010));
        check("t2_c3_wdata_s3", 64'(wdata_s[3*32 +: 32]), 64'(32'h1111_1111));
        check("t2_c3_wstrb_s", 64'(wstrb_s), 64'(24'hFF3FFF));
        tick();
        check("t2_outstanding_end", 64'(outstanding), 64'(0));
        check("t2_wready_m_end", 64'(wready_m), 64'(0));
        wvalid_m = '0;

        // Test 3: fill to full, ignored 5th push, drain intact
        push(0, 1);
        push(1, 2);
        push(2, 3);
        push(0, 4);
        check("t3_aw_ready_full", 64'(aw_ready), 64'(0));
        check("t3_outstanding_full", 64'(outstanding), 64'(4));
        push(2, 5);
        check("t3_outstanding_after_5th", 64'(outstanding), 64'(4));
        wvalid_m = 3'b111;
        wlast_m  = 3'b111;
        begin
            logic [5:0] exp_s [4];
            logic [2:0] exp_m [4];
            exp_s = '{6'b000010, 6'b000100, 6'b001000, 6'b010000};
            exp_m = '{3'b001, 3'b010, 3'b100, 3'b001};
            for (int k = 0; k < 4; k++) begin
                #1;
                check("t3_drain_wvalid_s", 64'(wvalid_s), 64'(exp_s[k]));
                check("t3_drain_wready_m", 64'(wready_m), 64'(exp_m[k]));
                tick();
            end
        end
        check("t3_outstanding_end", 64'(outstanding), 64'(0));
        check("t3_aw_ready_end", 64'(aw_ready), 64'(1));
        wvalid_m = '0;
        wlast_m  = '0;

        // Test 4: read-only slave S0 absorbs a 2-beat burst
        wready_s = 6'b000000;
        push(1, 0);
        wvalid_m[1] = 1'b1;
        set_beat(1, 32'hDEAD_0001, 4'hF, 1'b0);
        #1;
        check("t4_b1_wready_m", 64'(wready_m), 64'(3'b010));
        check("t4_b1_wvalid_s", 64'(wvalid_s), 64'(0));
        check("t4_b1_wr_err", 64'(wr_err), 64'(0));
        tick();
        set_beat(1, 32'hDEAD_0002, 4'hF, 1'b1);
        #1;
        check("t4_b2_wready_m", 64'(wready_m), 64'(3'b010));
        check("t4_b2_wvalid_s", 64'(wvalid_s), 64'(0));
        check("t4_b2_wr_err", 64'(wr_err), 64'(0));
        tick();
        wvalid_m = '0;
        wlast_m  = '0;
        check("t4_wr_err_pulse", 64'(wr_err), 64'(1));
        check("t4_outstanding", 64'(outstanding), 64'(0));
        tick();
        check("t4_wr_err_clear", 64'(wr_err), 64'(0));

        // Test 4b: out-of-range slave 6 is also sunk
        push(2, 6);
        wvalid_m[2] = 1'b1;
        set_beat(2, 32'hBEEF_0006, 4'hF, 1'b1);
        #1;
        check("t4b_wready_m", 64'(wready_m), 64'(3'b100));
        check("t4b_wvalid_s", 64'(wvalid_s), 64'(0));
        tick();
        wvalid_m = '0;
        wlast_m  = '0;
        check("t4b_wr_err_pulse", 64'(wr_err), 64'(1));
        tick();
        check("t4b_wr_err_clear", 64'(wr_err), 64'(0));

        // Test 5: slave backpressure 1,0,0,1,1,1 over a 4-beat burst
        push(1, 2);
        wvalid_m[1] = 1'b1;
        begin
            logic rdy_pat [6];
            int   k;
            rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            k = 0;
            for (int c = 0; c < 6; c++) begin
                wready_s = rdy_pat[c] ? 6'b000100 : 6'b000000;
                set_beat(1, 32'hC000_0000 + 32'(k), 4'hF, (k == 3));
                #1;
                check("t5_wready_m", 64'(wready_m), rdy_pat[c] ? 64'(3'b010) : 64'(0));
                check("t5_wdata_s2", 64'(wdata_s[2*32 +: 32]), 64'(32'hC000_0000 + 32'(k)));
                tick();
                if (rdy_pat[c]) k++;
            end
            check("t5_beats", 64'(k), 64'(4));
        end
        wvalid_m = '0;
        wlast_m  = '0;
        check("t5_outstanding_end", 64'(outstanding), 64'(0));

        // Test 6: reset mid-burst
        wready_s = 6'b111111;
        push(1, 2);
        wvalid_m[1] = 1'b1;
        set_beat(1, 32'hE000_0000, 4'hF, 1'b0);
        tick();
        set_beat(1, 32'hE000_0001, 4'hF, 1'b0);
        #1;
        check("t6_beat2_routed", 64'(wvalid_s), 64'(6'b000100));
        rst = 1'b1;
        #1;
        check("t6_rst_outstanding", 64'(outstanding), 64'(0));
        check("t6_rst_aw_ready", 64'(aw_ready), 64'(1));
        check_idle("t6_rst");
        rst = 1'b0;
        #1;
        check("t6_post_wready_m", 64'(wready_m), 64'(0));
        tick();
        check("t6_post2_wvalid_s", 64'(wvalid_s), 64'(0));
        check("t6_post2_outstanding", 64'(outstanding), 64'(0));
        wvalid_m = '0;
        tick();

        // Push with a single-beat burst on an empty FIFO
        aw_push     = 1'b1;
        aw_mst      = 2'd0;
        aw_slv      = 3'd3;
        wvalid_m[0] = 1'b1;
        set_beat(0, 32'h5A5A_0003, 4'hF, 1'b1);
        #1;
`ifdef AXI_WROUTE_BYPASS_EN
        check("byp_same_wvalid_s", 64'(wvalid_s), 64'(6'b001000));
        check("byp_same_wready_m", 64'(wready_m), 64'(3'b001));
        tick();
        aw_push  = 1'b0;
        wvalid_m = '0;
        #1;
        check("byp_outstanding", 64'(outstanding), 64'(0));
        check("byp_idle_after", 64'(wvalid_s), 64'(0));
`else
        check("nobyp_same_wvalid_s", 64'(wvalid_s), 64'(0));
        check("nobyp_same_wready_m", 64'(wready_m), 64'(0));
        tick();
        aw_push = 1'b0;
        #1;
        check("nobyp_outstanding", 64'(outstanding), 64'(1));
        check("nobyp_next_wvalid_s", 64'(wvalid_s), 64'(6'b001000));
        check("nobyp_next_wready_m", 64'(wready_m), 64'(3'b001));
        tick();
        wvalid_m = '0;
        check("nobyp_outstanding_end", 64'(outstanding), 64'(0));
`endif
        wlast_m = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
